// File: rtl/btn_debounce_n.sv
// Multi-channel push-button debouncer: sampled stability filter with press,
// release, long-press and toggle outputs, plus sticky falling-edge event flags.
module btn_debounce_n #(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned DIV        = 3125000,
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned LONG_CNT   = 40,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned N_EVT      = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BIN,
  input  logic [N_BTN-1:0] MODE,
  output logic [N_BTN-1:0] LEVEL,
  output logic [N_BTN-1:0] PRESS,
  output logic [N_BTN-1:0] RELEASE,
  output logic [N_BTN-1:0] LONG,
  output logic [N_BTN-1:0] TOGGLE,
  input  logic [N_EVT-1:0] EVT_IN,
  input  logic [N_EVT-1:0] EVT_CLR,
  output logic [N_EVT-1:0] EVT_FLAG
);

  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned STAB_W = 4;
  localparam int unsigned HOLD_W = 8;

  // Released level of the raw inputs; synchronizers idle here so reset never looks like a press.
  localparam logic [N_BTN-1:0] REL_LVL = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;

  logic [N_BTN-1:0]  sync_a;
  logic [N_BTN-1:0]  sync_b;
  logic [N_BTN-1:0]  norm;

  logic [STAB_W-1:0] stab_q   [N_BTN];
  logic [STAB_W-1:0] stab_nxt [N_BTN];
  logic [HOLD_W-1:0] hold_q   [N_BTN];
  logic [HOLD_W-1:0] hold_nxt [N_BTN];

  logic [N_BTN-1:0]  level_nxt;
  logic [N_BTN-1:0]  level_d;
  logic [N_BTN-1:0]  rise;
  logic [N_BTN-1:0]  fall;
  logic [N_BTN-1:0]  toggle_nxt;
  logic [N_BTN-1:0]  long_done;
  logic [N_BTN-1:0]  long_done_nxt;
  logic [N_BTN-1:0]  long_hit;

  logic [N_EVT-1:0]  evt_q;
  logic [N_EVT-1:0]  evt_qd;
  logic [N_EVT-1:0]  evt_fall;
  logic [N_EVT-1:0]  flag_nxt;

  // Sample-rate divider: one-cycle tick while the counter sits at DIV-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  // Two-flop synchronizer for the raw button pins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_a <= REL_LVL;
      sync_b <= REL_LVL;
    end else begin
      sync_a <= BIN;
      sync_b <= sync_a;
    end
  end

  assign norm = (ACTIVE_LOW != 0) ? ~sync_b : sync_b;

  // Per-channel stability filter and hold counter next-state.
  always_comb begin
    level_nxt     = LEVEL;
    long_hit      = '0;
    long_done_nxt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      stab_nxt[i] = stab_q[i];
      hold_nxt[i] = hold_q[i];

      if (tick) begin
        if (norm[i] == LEVEL[i]) begin
          stab_nxt[i] = '0;
        end else if (stab_q[i] == STAB_W'(STABLE_CNT - 1)) begin
          stab_nxt[i]  = '0;
          level_nxt[i] = ~LEVEL[i];
        end else begin
          stab_nxt[i] = stab_q[i] + STAB_W'(1);
        end
      end

      if (!LEVEL[i]) begin
        hold_nxt[i] = '0;
      end else if (tick && (hold_q[i] < HOLD_W'(LONG_CNT))) begin
        hold_nxt[i] = hold_q[i] + HOLD_W'(1);
      end

      // Saturated hold counter stays at LONG_CNT, so long_done gates repeats until release.
      long_hit[i]      = LEVEL[i] && !long_done[i] && (hold_q[i] == HOLD_W'(LONG_CNT));
      long_done_nxt[i] = LEVEL[i] && (long_done[i] || long_hit[i]);
    end
  end

  assign rise       = LEVEL & ~level_d;
  assign fall       = ~LEVEL & level_d;
  assign toggle_nxt = TOGGLE ^ (rise | (fall & MODE));

  // Debounced level, counters and one-cycle button pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LEVEL     <= '0;
      level_d   <= '0;
      PRESS     <= '0;
      RELEASE   <= '0;
      LONG      <= '0;
      TOGGLE    <= '0;
      long_done <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        stab_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      LEVEL     <= level_nxt;
      level_d   <= LEVEL;
      PRESS     <= rise;
      RELEASE   <= fall;
      LONG      <= long_hit;
      TOGGLE    <= toggle_nxt;
      long_done <= long_done_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        stab_q[i] <= stab_nxt[i];
        hold_q[i] <= hold_nxt[i];
      end
    end
  end

  assign evt_fall = evt_qd & ~evt_q;
  assign flag_nxt = (EVT_FLAG & ~EVT_CLR) | evt_fall;

  // Event strobe register and sticky falling-edge flags; a new edge beats a clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      evt_q    <= '0;
      evt_qd   <= '0;
      EVT_FLAG <= '0;
    end else begin
      evt_q    <= EVT_IN;
      evt_qd   <= evt_q;
      EVT_FLAG <= flag_nxt;
    end
  end

endmodule

// File: tb/tb_btn_debounce_n.sv
// Directed self-checking bench for btn_debounce_n (DIV=4, STABLE_CNT=3, LONG_CNT=5).
module tb_btn_debounce_n;

  localparam int unsigned NB = 4;
  localparam int unsigned NE = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NB-1:0] BIN;
  logic [NB-1:0] MODE;
  logic [NB-1:0] LEVEL;
  logic [NB-1:0] PRESS;
  logic [NB-1:0] RELEASE;
  logic [NB-1:0] LONG;
  logic [NB-1:0] TOGGLE;
  logic [NE-1:0] EVT_IN;
  logic [NE-1:0] EVT_CLR;
  logic [NE-1:0] EVT_FLAG;

  int n_tests = 0;
  int n_fail  = 0;
  int n_edge  = 0;

  int press_cnt [NB] = '{default: 0};
  int rel_cnt   [NB] = '{default: 0};
  int long_cnt  [NB] = '{default: 0};
  int p0 [NB];
  int r0 [NB];
  int l0 [NB];

  btn_debounce_n #(
    .N_BTN(NB), .DIV(4), .STABLE_CNT(3), .LONG_CNT(5), .ACTIVE_LOW(1), .N_EVT(NE)
  ) dut (
    .CLK(CLK), .RST(RST), .BIN(BIN), .MODE(MODE),
    .LEVEL(LEVEL), .PRESS(PRESS), .RELEASE(RELEASE), .LONG(LONG), .TOGGLE(TOGGLE),
    .EVT_IN(EVT_IN), .EVT_CLR(EVT_CLR), .EVT_FLAG(EVT_FLAG)
  );

  always #5 CLK = ~CLK;

  // Pulse counters sampled on the falling edge.
  always @(negedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (PRESS[i])   press_cnt[i] <= press_cnt[i] + 1;
      if (RELEASE[i]) rel_cnt[i]   <= rel_cnt[i] + 1;
      if (LONG[i])    long_cnt[i]  <= long_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    n_edge++;
  endtask

  task automatic steps(input int k);
    for (int j = 0; j < k; j++) step();
  endtask

  // Advance to just after the edge at which a sample tick takes effect.
  task automatic align();
    do step(); while (n_edge % 4 != 0);
  endtask

  task automatic snap();
    for (int i = 0; i < NB; i++) begin
      p0[i] = press_cnt[i];
      r0[i] = rel_cnt[i];
      l0[i] = long_cnt[i];
    end
  endtask

  initial begin
    RST = 1'b1; BIN = '1; MODE = '0; EVT_IN = '0; EVT_CLR = '0;
    steps(3);
    check("rst_level",   32'(LEVEL),    32'h0);
    check("rst_press",   32'(PRESS),    32'h0);
    check("rst_release", 32'(RELEASE),  32'h0);
    check("rst_long",    32'(LONG),     32'h0);
    check("rst_toggle",  32'(TOGGLE),   32'h0);
    check("rst_flag",    32'(EVT_FLAG), 32'h0);
    RST = 1'b0;
    n_edge = 0;
    steps(6);

    // Clean press and release on channel 0
    snap();
    align();
    BIN[0] = 1'b0;
    steps(11);
    check("cp_level_pre", 32'(LEVEL), 32'h0);
    step();
    check("cp_level",     32'(LEVEL), 32'h1);
    check("cp_press_pre", 32'(PRESS), 32'h0);
    step();
    check("cp_press",     32'(PRESS),  32'h1);
    check("cp_toggle",    32'(TOGGLE), 32'h1);
    step();
    check("cp_press_end", 32'(PRESS), 32'h0);
    BIN[0] = 1'b1;
    steps(20);
    check("cp_level_rel", 32'(LEVEL), 32'h0);
    check("cp_npress",    32'(press_cnt[0] - p0[0]), 32'd1);
    check("cp_nrel",      32'(rel_cnt[0] - r0[0]),   32'd1);
    check("cp_nlong",     32'(long_cnt[0] - l0[0]),  32'd0);
    check("cp_toggle_hold", 32'(TOGGLE[0]), 32'd1);

    // Bounce on channel 1
    snap();
    for (int i = 0; i < 40; i++) begin
      BIN[1] = ((i / 6) % 2 == 0) ? 1'b0 : 1'b1;
      step();
    end
    BIN[1] = 1'b0;
    check("bn_npress_bounce", 32'(press_cnt[1] - p0[1]), 32'd0);
    check("bn_level_bounce",  32'(LEVEL[1]), 32'd0);
    steps(20);
    check("bn_npress", 32'(press_cnt[1] - p0[1]), 32'd1);
    check("bn_level",  32'(LEVEL[1]), 32'd1);
    BIN[1] = 1'b1;
    steps(20);
    check("bn_nrel",   32'(rel_cnt[1] - r0[1]), 32'd1);

    // Long press on channel 2
    snap();
    align();
    BIN[2] = 1'b0;
    steps(32);
    check("lp_long_pre", 32'(LONG), 32'h0);
    step();
    check("lp_long",     32'(LONG), 32'h4);
    step();
    check("lp_long_end", 32'(LONG), 32'h0);
    steps(40);
    BIN[2] = 1'b1;
    steps(20);
    check("lp_npress", 32'(press_cnt[2] - p0[2]), 32'd1);
    check("lp_nlong",  32'(long_cnt[2] - l0[2]),  32'd1);
    check("lp_nrel",   32'(rel_cnt[2] - r0[2]),   32'd1);

    // Short press on channel 2: no long pulse
    snap();
    align();
    BIN[2] = 1'b0;
    steps(14);
    BIN[2] = 1'b1;
    steps(20);
    check("sp_npress", 32'(press_cnt[2] - p0[2]), 32'd1);
    check("sp_nlong",  32'(long_cnt[2] - l0[2]),  32'd0);
    check("sp_nrel",   32'(rel_cnt[2] - r0[2]),   32'd1);

    // Toggle modes on channel 3
    MODE[3] = 1'b1;
    snap();
    align();
    BIN[3] = 1'b0;
    steps(14);
    check("tm1_press", 32'(TOGGLE[3]), 32'd1);
    BIN[3] = 1'b1;
    steps(20);
    check("tm1_rel",   32'(TOGGLE[3]), 32'd0);
    check("tm1_nrel",  32'(rel_cnt[3] - r0[3]), 32'd1);
    MODE[3] = 1'b0;
    align();
    BIN[3] = 1'b0;
    steps(14);
    check("tm0_press", 32'(TOGGLE[3]), 32'd1);
    BIN[3] = 1'b1;
    steps(20);
    check("tm0_rel",   32'(TOGGLE[3]), 32'd1);

    // Sticky event flags
    EVT_IN = 2'b01;
    steps(3);
    EVT_IN = 2'b00;
    step();
    check("ev_flag_early", 32'(EVT_FLAG), 32'h0);
    step();
    check("ev_flag_set",   32'(EVT_FLAG), 32'h1);
    EVT_CLR = 2'b01;
    step();
    EVT_CLR = 2'b00;
    check("ev_flag_clr",   32'(EVT_FLAG), 32'h0);
    EVT_IN = 2'b01;
    steps(3);
    EVT_IN = 2'b00;
    step();
    EVT_CLR = 2'b01;
    step();
    EVT_CLR = 2'b00;
    check("ev_set_wins",   32'(EVT_FLAG), 32'h1);
    step();
    check("ev_flag_hold",  32'(EVT_FLAG), 32'h1);
    EVT_CLR = 2'b01;
    step();
    EVT_CLR = 2'b00;
    check("ev_flag_clr2",  32'(EVT_FLAG), 32'h0);

    // Reset mid-debounce on channel 0
    align();
    BIN[0] = 1'b0;
    steps(8);
    check("rs_toggle_before", 32'(TOGGLE), 32'hB);
    RST = 1'b1;
    #1;
    check("rs_level",  32'(LEVEL),  32'h0);
    check("rs_toggle", 32'(TOGGLE), 32'h0);
    check("rs_press",  32'(PRESS),  32'h0);
    steps(2);
    RST = 1'b0;
    n_edge = 0;
    snap();
    steps(11);
    check("rs_level_pre", 32'(LEVEL), 32'h0);
    step();
    check("rs_level_on",  32'(LEVEL), 32'h1);
    check("rs_press_pre", 32'(PRESS), 32'h0);
    step();
    check("rs_press",     32'(PRESS), 32'h1);
    steps(5);
    check("rs_npress", 32'(press_cnt[0] - p0[0]), 32'd1);
    check("rs_nrel",   32'((rel_cnt[0] - r0[0]) + (rel_cnt[1] - r0[1]) +
                           (rel_cnt[2] - r0[2]) + (rel_cnt[3] - r0[3])), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce_n.md
BTN_DEBOUNCE_N -- requirements
Module: btn_debounce_n

Interface
REQ-001 The block SHALL use the following parameters, one per line (name, default, meaning):
  N_BTN, 4, number of button channels.
  DIV, 3125000, CLK cycles per sample tick (40 Hz at 125 MHz).
  STABLE_CNT, 3, consecutive equal samples required to accept a new level (range 1..15).
  LONG_CNT, 40, ticks held before the long-press pulse (range 1..255).
  ACTIVE_LOW, 1, 1 = raw input 0 means pressed.
  N_EVT, 2, number of sticky event-latch channels.
REQ-002 The block SHALL have the following ports, one per line (name  direction  width  meaning):
  CLK  in  1  clock.
  RST  in  1  reset, asynchronous, active-high.
  BIN  in  N_BTN  raw asynchronous button inputs.
  MODE  in  N_BTN  per channel: 0 = TOGGLE flips on press only; 1 = TOGGLE flips on press and on release.
  LEVEL  out  N_BTN  debounced state, 1 = pressed.
  PRESS  out  N_BTN  1-CLK pulse on debounced press.
  RELEASE  out  N_BTN  1-CLK pulse on debounced release.
  LONG  out  N_BTN  1-CLK pulse, at most once per press.
  TOGGLE  out  N_BTN  toggle state.
  EVT_IN  in  N_EVT  synchronous handshake strobes from the datapath.
  EVT_CLR  in  N_EVT  synchronous clear of the sticky flags.
  EVT_FLAG  out  N_EVT  sticky falling-edge flags (LED drive).

Function
REQ-003 The tick counter SHALL count 0..DIV-1 and wrap to 0, asserting tick for exactly one CLK while its value is DIV-1.
REQ-004 Each BIN bit SHALL pass through a 2-flop synchronizer clocked every CLK, followed by polarity normalization (pressed = 1).
REQ-005 On each tick, per channel: if the normalized sample equals LEVEL, the stability counter SHALL clear; otherwise it SHALL increment, and on reaching STABLE_CNT, LEVEL SHALL invert and the counter SHALL clear.
REQ-006 Between ticks, LEVEL and the stability counters SHALL hold.
REQ-007 PRESS (RELEASE) SHALL be high for exactly the one CLK following the cycle in which LEVEL goes 0->1 (1->0); latency is 1 CLK after the LEVEL change.
REQ-008 TOGGLE SHALL invert in the same cycle PRESS is high; when MODE=1 it SHALL also invert in the same cycle RELEASE is high. MODE SHALL be sampled in that cycle.
REQ-009 The 8-bit hold counter SHALL clear while LEVEL=0 and SHALL increment on each tick while LEVEL=1, saturating at LONG_CNT.
REQ-010 LONG SHALL pulse for one CLK in the cycle after the hold counter first reaches LONG_CNT; no further LONG is issued until LEVEL returns to 0.
REQ-011 A release before LONG_CNT is reached SHALL produce no LONG.
REQ-012 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-013 EVT_IN SHALL be registered once per CLK; a 1->0 transition of the registered value SHALL set EVT_FLAG on the next CLK.
REQ-014 EVT_CLR=1 SHALL clear EVT_FLAG on the next CLK; if set and clear coincide, set SHALL win.
REQ-015 All logic SHALL be in the CLK domain; no edge-triggered logic on data signals.

Reset
REQ-016 While RST=1: tick counter, stability counters, hold counters, LEVEL, PRESS, RELEASE, LONG, TOGGLE and EVT_FLAG SHALL be 0.
REQ-017 While RST=1, synchronizer flops SHALL hold the released level (1 when ACTIVE_LOW=1), and the EVT_IN register SHALL be 0.
REQ-018 Reset asserted mid-debounce or mid-hold SHALL abandon the operation; after release, an input held pressed SHALL require a full STABLE_CNT ticks before PRESS.

Verification (DIV=4, STABLE_CNT=3, LONG_CNT=5, ACTIVE_LOW=1, N_BTN=4)
REQ-019 Clean press: BIN[0] 1->0 and held -> LEVEL[0]=1 at the 3rd tick after sync, PRESS[0] pulses 1 CLK later, TOGGLE[0]=1, no other channel changes.
REQ-020 Bounce: BIN[1] alternates every 6 CLK for 40 CLK, then settles at 0 -> no PRESS during the bounce, exactly one PRESS after 3 stable ticks.
REQ-021 Long press: BIN[2]=0 held for 12 ticks -> PRESS once, LONG once at hold count 5, release -> RELEASE once and no second LONG; a 3-tick press -> no LONG.
REQ-022 MODE[3]=1: press then release -> TOGGLE[3] goes 0->1->0; MODE[3]=0, same stimulus -> 0->1 and stays 1.
REQ-023 Event flags: EVT_IN[0] 1->0 -> EVT_FLAG[0]=1 two CLK later; EVT_CLR[0] pulse -> 0; falling edge and EVT_CLR in the same cycle -> flag stays 1.
REQ-024 Reset: RST asserted mid-debounce with BIN=0 -> all outputs 0 immediately; after RST release with BIN still 0 -> PRESS only after 3 further ticks, with no spurious RELEASE.
